// File: rtl/tk1_exec_mon.sv
// tk1_exec_mon: CPU memory-access monitor for the tk1 core.
// Checks every valid CPU access against NUM_WIN configurable address
// windows plus a fixed firmware RAM exec guard. A violation raises
// force_trap in the same cycle. The first offending address and window
// are recorded, and a saturating counter tracks every violating cycle.

module tk1_exec_mon #(
    parameter int          NUM_WIN      = 4,
    parameter int          CTR_WIDTH    = 16,
    parameter bit          TRAP_STICKY  = 1'b0,
    parameter logic [31:0] FW_RAM_FIRST = 32'hd0000000,
    parameter logic [31:0] FW_RAM_LAST  = 32'hd00007ff
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fw_app_mode,
    input  logic        cpu_valid,
    input  logic        cpu_instr,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    output logic        force_trap,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready
);

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h01;
    localparam logic [7:0] ADDR_COUNT  = 8'h02;
    localparam logic [7:0] ADDR_VADDR  = 8'h03;
    localparam int         ADDR_FIRST0 = 'h10;
    localparam int         ADDR_MODE0  = 'h30;
    localparam logic [3:0] WIN_FW_RAM  = 4'hf;

    logic                 ctrl_en;
    logic                 ctrl_lock;
    logic                 viol;
    logic [3:0]           viol_win;
    logic [31:0]          viol_addr;
    logic [CTR_WIDTH-1:0] viol_count;
    logic                 sticky_trap;

    logic [31:0]          win_first [NUM_WIN];
    logic [31:0]          win_last  [NUM_WIN];
    logic [1:0]           win_mode  [NUM_WIN];

    logic [NUM_WIN-1:0]   win_hit;
    logic [3:0]           first_hit_idx;
    logic                 fw_hit;
    logic                 violation;
    logic                 api_write;
    logic                 cfg_write_ok;
    logic                 status_clear;
    logic [31:0]          count_ext;
    logic [31:0]          rd_mux;

    assign api_write    = cs & we;
    assign cfg_write_ok = api_write & ~ctrl_lock & ~fw_app_mode;
    assign status_clear = api_write & ~fw_app_mode & (address == ADDR_STATUS);
    assign count_ext    = 32'(viol_count);

    // Per-window hit: inclusive unsigned range plus the deny mode for this access type.
    // An inverted range (FIRST > LAST) can never satisfy both compares, so it never hits.
    always_comb begin
        win_hit = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            win_hit[i] = ctrl_en & cpu_valid
                       & (win_first[i] <= cpu_addr) & (cpu_addr <= win_last[i])
                       & ((win_mode[i][0] & cpu_instr) | (win_mode[i][1] & cpu_write));
        end
    end

    // Lowest-index hitting window wins; the firmware RAM code only shows up when no window hits.
    always_comb begin
        first_hit_idx = WIN_FW_RAM;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (win_hit[i]) begin
                first_hit_idx = 4'(i);
            end
        end
    end

    assign fw_hit = cpu_valid & cpu_instr
                  & (FW_RAM_FIRST <= cpu_addr) & (cpu_addr <= FW_RAM_LAST);

    assign violation = (|win_hit) | fw_hit;

    // Gate with reset_n so the trap drops the moment reset is asserted.
    assign force_trap = reset_n & (violation | (TRAP_STICKY & sticky_trap));

    // CTRL bits are set-only; once EN or LOCK is written to 1 it stays until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en   <= 1'b0;
            ctrl_lock <= 1'b0;
        end else if (api_write && address == ADDR_CTRL) begin
            ctrl_en   <= ctrl_en   | write_data[0];
            ctrl_lock <= ctrl_lock | write_data[1];
        end
    end

    // Window FIRST/LAST/MODE registers, writable only in firmware mode before LOCK.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                win_first[i] <= '0;
                win_last[i]  <= '0;
                win_mode[i]  <= '0;
            end
        end else if (cfg_write_ok) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                if (address == 8'(ADDR_FIRST0 + 2 * i)) begin
                    win_first[i] <= write_data;
                end
                if (address == 8'(ADDR_FIRST0 + 2 * i + 1)) begin
                    win_last[i] <= write_data;
                end
                if (address == 8'(ADDR_MODE0 + i)) begin
                    win_mode[i] <= write_data[1:0];
                end
            end
        end
    end

    // Violation recording; a violation in the same cycle as a status clear
    // restarts the record from this violation instead of being lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            viol       <= 1'b0;
            viol_win   <= '0;
            viol_addr  <= '0;
            viol_count <= '0;
        end else if (violation) begin
            viol <= 1'b1;
            if (!viol || status_clear) begin
                viol_addr <= cpu_addr;
                viol_win  <= first_hit_idx;
            end
            if (status_clear) begin
                viol_count <= CTR_WIDTH'(1);
            end else if (viol_count != {CTR_WIDTH{1'b1}}) begin
                viol_count <= viol_count + 1'b1;
            end
        end else if (status_clear) begin
            viol       <= 1'b0;
            viol_win   <= '0;
            viol_addr  <= '0;
            viol_count <= '0;
        end
    end

    // Sticky trap flag: remembers that any violation happened since reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_trap <= 1'b0;
        end else if (violation) begin
            sticky_trap <= 1'b1;
        end
    end

    // API read mux; unmapped addresses fall through to zero.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_CTRL:   rd_mux = {30'd0, ctrl_lock, ctrl_en};
            ADDR_STATUS: rd_mux = {20'd0, viol_win, 7'd0, viol};
            ADDR_COUNT:  rd_mux = count_ext;
            ADDR_VADDR:  rd_mux = viol_addr;
            default:     rd_mux = '0;
        endcase
        for (int i = 0; i < NUM_WIN; i++) begin
            if (address == 8'(ADDR_FIRST0 + 2 * i)) begin
                rd_mux = win_first[i];
            end
            if (address == 8'(ADDR_FIRST0 + 2 * i + 1)) begin
                rd_mux = win_last[i];
            end
            if (address == 8'(ADDR_MODE0 + i)) begin
                rd_mux = {30'd0, win_mode[i]};
            end
        end
    end

    assign read_data = (reset_n & cs & ~we) ? rd_mux : 32'd0;
    assign ready     = reset_n & cs;

endmodule

// File: tb/tb_tk1_exec_mon.sv
// Testbench for tk1_exec_mon: two instances share stimulus, one with default
// parameters and one with CTR_WIDTH=8 / TRAP_STICKY=1, both checked against
// a behavioural model of the register map and violation rules.

module tb_tk1_exec_mon;

    logic        clk;
    logic        reset_n;
    logic        fw_app_mode;
    logic        cpu_valid;
    logic        cpu_instr;
    logic        cpu_write;
    logic [31:0] cpu_addr;
    logic        cs;
    logic        we;
    logic [7:0]  address;
    logic [31:0] write_data;

    logic        trap_a, trap_s;
    logic        ready_a, ready_s;
    logic [31:0] read_a, read_s;

    int unsigned num_compared = 0;
    int unsigned num_mismatched = 0;

    // Model state
    logic        m_en, m_lock, m_viol, m_sticky;
    logic [3:0]  m_win;
    logic [31:0] m_addr;
    int unsigned m_count;
    logic [31:0] m_first [4];
    logic [31:0] m_last  [4];
    logic [1:0]  m_mode  [4];

    logic        last_trap_a, last_trap_s;
    logic [31:0] last_read_a, last_read_s;

    tk1_exec_mon dut_a (
        .clk(clk), .reset_n(reset_n), .fw_app_mode(fw_app_mode),
        .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .force_trap(trap_a),
        .cs(cs), .we(we), .address(address), .write_data(write_data),
        .read_data(read_a), .ready(ready_a)
    );

    tk1_exec_mon #(.CTR_WIDTH(8), .TRAP_STICKY(1'b1)) dut_s (
        .clk(clk), .reset_n(reset_n), .fw_app_mode(fw_app_mode),
        .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .force_trap(trap_s),
        .cs(cs), .we(we), .address(address), .write_data(write_data),
        .read_data(read_s), .ready(ready_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_compared++;
        if (observed !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic void modelReset();
        m_en = 0; m_lock = 0; m_viol = 0; m_sticky = 0;
        m_win = 0; m_addr = 0; m_count = 0;
        for (int i = 0; i < 4; i++) begin
            m_first[i] = 0; m_last[i] = 0; m_mode[i] = 0;
        end
    endfunction

    // Is the current access a violation, and which window code would be recorded?
    function automatic void modelAccess(output logic hit, output logic [3:0] win);
        logic denied;
        hit = 0;
        win = 4'hf;
        for (int i = 0; i < 4; i++) begin
            denied = (m_mode[i][0] && cpu_instr) || (m_mode[i][1] && cpu_write);
            if (!hit && m_en && cpu_valid && denied &&
                cpu_addr >= m_first[i] && cpu_addr <= m_last[i]) begin
                hit = 1;
                win = 4'(i);
            end
        end
        if (!hit && cpu_valid && cpu_instr &&
            cpu_addr >= 32'hd0000000 && cpu_addr <= 32'hd00007ff) begin
            hit = 1;
        end
    endfunction

    function automatic logic [31:0] modelRead(input logic [7:0] a, input int unsigned max_count);
        int idx;
        if (a == 8'h00) return {30'd0, m_lock, m_en};
        if (a == 8'h01) return {20'd0, m_win, 7'd0, m_viol};
        if (a == 8'h02) return (m_count > max_count) ? max_count : m_count;
        if (a == 8'h03) return m_addr;
        if (a >= 8'h10 && a <= 8'h17) begin
            idx = (int'(a) - 'h10) / 2;
            return a[0] ? m_last[idx] : m_first[idx];
        end
        if (a >= 8'h30 && a <= 8'h33) begin
            idx = int'(a) - 'h30;
            return {30'd0, m_mode[idx]};
        end
        return 0;
    endfunction

    function automatic void modelEdge(input logic hit, input logic [3:0] win);
        logic wr, cfg_ok;
        int idx;
        wr = cs && we;
        cfg_ok = wr && !m_lock && !fw_app_mode;
        if (wr && address == 8'h00) begin
            m_en = m_en | write_data[0];
            m_lock = m_lock | write_data[1];
        end
        if (cfg_ok && address >= 8'h10 && address <= 8'h17) begin
            idx = (int'(address) - 'h10) / 2;
            if (address[0]) m_last[idx] = write_data;
            else            m_first[idx] = write_data;
        end
        if (cfg_ok && address >= 8'h30 && address <= 8'h33) begin
            m_mode[int'(address) - 'h30] = write_data[1:0];
        end
        if (wr && address == 8'h01 && !fw_app_mode) begin
            m_viol = 0; m_win = 0; m_addr = 0; m_count = 0;
        end
        if (hit) begin
            if (!m_viol) begin
                m_addr = cpu_addr;
                m_win = win;
            end
            m_viol = 1;
            m_count++;
            m_sticky = 1;
        end
    endfunction

    // Drive one cycle of inputs, check combinational outputs mid-cycle, advance the model.
    task automatic applyStimulus(input logic v, input logic ins, input logic wr,
                                 input logic [31:0] a, input logic c, input logic w,
                                 input logic [7:0] ad, input logic [31:0] wd);
        logic hit;
        logic [3:0] win;
        cpu_valid = v; cpu_instr = ins; cpu_write = wr; cpu_addr = a;
        cs = c; we = w; address = ad; write_data = wd;
        @(negedge clk);
        modelAccess(hit, win);
        checkOutput("trap_a", 32'(trap_a), 32'(hit));
        checkOutput("trap_s", 32'(trap_s), 32'(hit | m_sticky));
        checkOutput("ready_a", 32'(ready_a), 32'(c));
        checkOutput("ready_s", 32'(ready_s), 32'(c));
        checkOutput($sformatf("rd_a@%02h", ad), read_a, (c && !w) ? modelRead(ad, 65535) : 32'd0);
        checkOutput($sformatf("rd_s@%02h", ad), read_s, (c && !w) ? modelRead(ad, 255) : 32'd0);
        last_trap_a = trap_a; last_trap_s = trap_s;
        last_read_a = read_a; last_read_s = read_s;
        modelEdge(hit, win);
        @(posedge clk);
        #1;
    endtask

    task automatic apiWrite(input logic [7:0] ad, input logic [31:0] wd);
        applyStimulus(0, 0, 0, 32'd0, 1, 1, ad, wd);
    endtask

    task automatic apiRead(input logic [7:0] ad);
        applyStimulus(0, 0, 0, 32'd0, 1, 0, ad, 32'd0);
    endtask

    task automatic access(input logic ins, input logic wr, input logic [31:0] a);
        applyStimulus(1, ins, wr, a, 0, 0, 8'd0, 32'd0);
    endtask

    // Reset pulse between clock edges, with a violating fetch and an API read active.
    task automatic doReset();
        cpu_valid = 1; cpu_instr = 1; cpu_write = 0; cpu_addr = 32'hd0000010;
        cs = 1; we = 0; address = 8'h01; write_data = 0;
        reset_n = 0;
        #1;
        checkOutput("rst_trap_a", 32'(trap_a), 32'd0);
        checkOutput("rst_trap_s", 32'(trap_s), 32'd0);
        checkOutput("rst_ready", 32'(ready_a), 32'd0);
        checkOutput("rst_rd_s", read_s, 32'd0);
        modelReset();
        cpu_valid = 0; cpu_instr = 0; cs = 0;
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] randCpuAddr();
        if ($urandom_range(0, 4) == 0) return 32'hd0000000 + $urandom_range(0, 32'h900) - 32'd8;
        return $urandom_range(0, 32'h3fff);
    endfunction

    function automatic logic [7:0] randApiAddr();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 3) return 8'(r);
        if (r <= 6) return 8'(8'h10 + $urandom_range(0, 9));
        if (r == 7) return 8'(8'h30 + $urandom_range(0, 4));
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        logic [31:0] f;
        logic [7:0] ad;
        logic c, w;
        logic [31:0] wd;

        reset_n = 0; fw_app_mode = 0;
        cpu_valid = 0; cpu_instr = 0; cpu_write = 0; cpu_addr = 0;
        cs = 0; we = 0; address = 0; write_data = 0;
        modelReset();
        @(posedge clk);
        #1;
        doReset();
        apiRead(8'h00);
        checkOutput("reset_ctrl", last_read_a, 32'd0);

        // Firmware RAM exec guard, active without EN
        access(1, 0, 32'hd0000100);
        checkOutput("fw_trap", 32'(last_trap_a), 32'd1);
        apiRead(8'h01);
        checkOutput("fw_status", last_read_a, 32'h00000f01);
        apiRead(8'h03);
        checkOutput("fw_vaddr", last_read_a, 32'hd0000100);
        apiRead(8'h02);
        checkOutput("fw_count", last_read_a, 32'd1);

        // Window 0 write-deny
        apiWrite(8'h01, 0);
        apiWrite(8'h10, 32'h1000);
        apiWrite(8'h11, 32'h1fff);
        apiWrite(8'h30, 32'h2);
        apiWrite(8'h00, 32'h1);
        access(0, 1, 32'h1ffc);
        checkOutput("w0_trap", 32'(last_trap_a), 32'd1);
        apiRead(8'h01);
        checkOutput("w0_status", last_read_a, 32'h00000001);
        access(0, 1, 32'h2000);
        checkOutput("w0_past_last", 32'(last_trap_a), 32'd0);
        access(1, 0, 32'h1800);
        checkOutput("w0_fetch_ok", 32'(last_trap_a), 32'd0);

        // Overlapping windows 1 and 2
        apiWrite(8'h01, 0);
        apiWrite(8'h12, 32'h3000);
        apiWrite(8'h13, 32'h4fff);
        apiWrite(8'h31, 32'h1);
        apiWrite(8'h14, 32'h4000);
        apiWrite(8'h15, 32'h6000);
        apiWrite(8'h32, 32'h1);
        access(1, 0, 32'h4000);
        apiRead(8'h01);
        checkOutput("ovl_status", last_read_a, 32'h00000101);
        access(1, 0, 32'h5000);
        apiRead(8'h03);
        checkOutput("ovl_vaddr", last_read_a, 32'h4000);
        apiRead(8'h02);
        checkOutput("ovl_count", last_read_a, 32'd2);

        // LOCK and app-mode protection
        apiWrite(8'h00, 32'h2);
        apiWrite(8'h10, 32'h0);
        apiRead(8'h10);
        checkOutput("lock_first0", last_read_a, 32'h1000);
        fw_app_mode = 1;
        apiWrite(8'h01, 0);
        apiRead(8'h01);
        checkOutput("app_noclear", last_read_a, 32'h00000101);
        fw_app_mode = 0;

        // Counter saturation on the 8-bit instance, then clear racing a violation
        for (int i = 0; i < 300; i++) access(1, 0, 32'hd0000000);
        apiRead(8'h02);
        checkOutput("sat_s", last_read_s, 32'd255);
        checkOutput("nosat_a", last_read_a, 32'd302);
        applyStimulus(1, 1, 0, 32'hd0000004, 1, 1, 8'h01, 32'd0);
        apiRead(8'h02);
        checkOutput("clr_race_cnt_s", last_read_s, 32'd1);
        checkOutput("clr_race_cnt_a", last_read_a, 32'd1);
        apiRead(8'h01);
        checkOutput("clr_race_status", last_read_s, 32'h00000f01);
        apiRead(8'h03);
        checkOutput("clr_race_vaddr", last_read_a, 32'hd0000004);

        // Sticky trap survives clean accesses, cleared by reset
        access(0, 0, 32'h100);
        checkOutput("sticky_hold", 32'(last_trap_s), 32'd1);
        checkOutput("nonsticky", 32'(last_trap_a), 32'd0);
        doReset();
        access(0, 0, 32'h100);
        checkOutput("sticky_cleared", 32'(last_trap_s), 32'd0);

        // Randomized rounds against the model
        for (int round = 0; round < 3; round++) begin
            doReset();
            fw_app_mode = 0;
            for (int i = 0; i < 4; i++) begin
                f = $urandom_range(0, 32'h3000);
                apiWrite(8'(8'h10 + 2 * i), f);
                if ($urandom_range(0, 5) == 0) apiWrite(8'(8'h11 + 2 * i), f - 1);
                else apiWrite(8'(8'h11 + 2 * i), f + $urandom_range(0, 32'h1000));
                apiWrite(8'(8'h30 + i), $urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) != 0) apiWrite(8'h00, 32'h1);
            for (int n = 0; n < 1000; n++) begin
                if ($urandom_range(0, 99) == 0) fw_app_mode = ~fw_app_mode;
                if ($urandom_range(0, 499) == 0) doReset();
                c = ($urandom_range(0, 3) == 0);
                w = c && ($urandom_range(0, 7) == 0);
                ad = randApiAddr();
                wd = $urandom;
                if (ad == 8'h00) wd = {30'd0, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1))};
                applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), randCpuAddr(), c, w, ad, wd);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule

// File: doc/tk1_exec_mon.md
Name: tk1_exec_mon

Overview:
Parametrised CPU memory-access monitor that succeeds the single-window execution monitor in the tk1 core. It checks every valid CPU bus access against NUM_WIN address windows. Each window has its own deny mode: exec, write, or both. The firmware RAM exec guard is always active. On a violation the block asserts force_trap, records the first offending address and window, and counts violations. It sits on the tk1 API bus beside tk1 and drives the CPU trap input.

Parameters:
NUM_WIN, 4, number of monitor windows; legal range 1..8.
CTR_WIDTH, 16, width of the saturating violation counter; legal range 8..32.
TRAP_STICKY, 0, when 1 force_trap stays high after the first violation until reset.
FW_RAM_FIRST, 32'hd0000000, first address of the firmware RAM exec-deny region (inclusive).
FW_RAM_LAST, 32'hd00007ff, last address of the firmware RAM exec-deny region (inclusive).

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
fw_app_mode  in  1  0 = firmware mode, 1 = app mode
cpu_valid  in  1  CPU bus access valid
cpu_instr  in  1  access is an instruction fetch
cpu_write  in  1  access is a data write
cpu_addr  in  32  CPU access address
force_trap  out  1  trap request to the CPU
cs  in  1  API chip select
we  in  1  API write enable
address  in  8  API word address
write_data  in  32  API write data
read_data  out  32  API read data
ready  out  1  API ready

Behaviour:
- Reset: asserting reset_n low clears all registers at once, independent of clk: CTRL, STATUS, VIOL_ADDR, counter, all FIRST/LAST/MODE, and the sticky trap flag. Outputs while reset is asserted: force_trap=0, ready=0, read_data=0.
- Register map:
  - 0x00 CTRL: bit0 EN, bit1 LOCK. Writing 1 sets a bit; writing 0 has no effect. Both bits stay set until reset.
  - 0x01 STATUS (read-only fields): bit0 VIOL (sticky); bits[11:8] WIN = index of first violating window, 4'hf = firmware RAM guard.
  - 0x02 VIOL_COUNT: zero-extended to 32 bits.
  - 0x03 VIOL_ADDR: address of the first violation.
  - 0x10+2i FIRST_i and 0x11+2i LAST_i, for i < NUM_WIN.
  - 0x30+i MODE_i: bit0 DENY_EXEC, bit1 DENY_WRITE.
  - Unmapped addresses read 0; writes to them are ignored.
- API timing: ready = cs in the same cycle. read_data is combinational and is 0 when cs=0 or we=1. Writes take effect at the next clk edge.
- Window configuration: writes to FIRST/LAST/MODE are ignored when LOCK=1 or fw_app_mode=1. Reads always return the current values.
- Clearing status: any write to 0x01 while fw_app_mode=0 clears VIOL, WIN, VIOL_ADDR and VIOL_COUNT.
- Window hit for window i: EN=1 and cpu_valid=1 and FIRST_i <= cpu_addr <= LAST_i (unsigned, inclusive) and one of:
  - DENY_EXEC=1 and cpu_instr=1, or
  - DENY_WRITE=1 and cpu_write=1.
  - If FIRST_i > LAST_i, window i never hits. MODE_i=0 disables window i.
- Firmware RAM hit: cpu_valid=1 and cpu_instr=1 and FW_RAM_FIRST <= cpu_addr <= FW_RAM_LAST. This guard ignores EN.
- Violation: any window hit or the firmware RAM hit.
- force_trap: combinational = violation, OR sticky_trap_reg when TRAP_STICKY=1. Latency 0 from cpu_valid.
  - sticky_trap_reg sets on the clk edge after a violation.
- Recording, at the clk edge of a violation:
  - If VIOL=0: set VIOL, load VIOL_ADDR=cpu_addr, load WIN. WIN is the lowest-index hitting window; if only the firmware RAM guard hit, WIN=4'hf. The firmware RAM guard takes priority over windows only when no window hits.
  - If VIOL=1: VIOL_ADDR and WIN hold.
  - VIOL_COUNT increments by 1 on every violating cycle and saturates at 2^CTR_WIDTH-1 (no wrap).
- Simultaneous status clear and violation in the same cycle: the violation wins. Result: VIOL=1, VIOL_COUNT=1, and VIOL_ADDR/WIN take the new violation's values.
- Simultaneous CTRL.EN write and access: EN takes effect from the next cycle, so the access in the write cycle is checked with the old EN.
- Reset mid-violation: force_trap drops immediately when reset_n goes low, including when TRAP_STICKY=1.

Test Plan:
- Reset, then fetch at 32'hd0000100 with cpu_valid=1, cpu_instr=1 -> force_trap=1 in the same cycle; next cycle STATUS=32'h0000_0f01, VIOL_ADDR=32'hd0000100, VIOL_COUNT=1.
- Configure window 0 as 0x00001000..0x00001fff with MODE_0=2'b10, EN=1; data write to 0x1ffc -> trap, WIN=0. Write to 0x2000 -> no trap. Fetch at 0x1800 -> no trap.
- Windows 1 and 2 overlap at 0x4000; both have exec-deny; fetch at 0x4000 -> WIN=1. A second violation at 0x5000 -> VIOL_ADDR stays 0x4000 and VIOL_COUNT=2.
- Set LOCK=1, then write FIRST_0=0 -> FIRST_0 unchanged. Set fw_app_mode=1, then write 0x01 -> status not cleared.
- CTR_WIDTH=8, 300 consecutive violating cycles -> VIOL_COUNT=255. A clear write that coincides with a violating cycle -> VIOL_COUNT=1 and VIOL=1.
- TRAP_STICKY=1: one violating cycle, then clean accesses -> force_trap stays 1. Pulse reset_n low between clk edges -> force_trap=0 immediately.
